// File: rtl/map_pattern_gen_pkg.sv
// Shared encodings for the card-map stimulus source: map modes, selection modes, FSM states.
package map_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_ROTATE = 2'd2,
    MODE_AUTO   = 2'd3
  } map_mode_e;

  typedef enum logic [1:0] {
    SEL_TOGGLE = 2'd0,
    SEL_WALK   = 2'd1,
    SEL_CHECK  = 2'd2,
    SEL_CLEAR  = 2'd3
  } sel_mode_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/map_pattern_gen_if.sv
// Control and map bus between the pattern generator and the display harness.
interface map_pattern_gen_if #(
  parameter int unsigned SLOTS  = 144,
  parameter int unsigned CARD_W = 6
);
  logic                      reinit;
  logic                      step;
  logic                      sel_step;
  logic [1:0]                mode;
  logic [1:0]                sel_mode;
  logic [CARD_W-1:0]         fill_card;
  logic [SLOTS*CARD_W-1:0]   map;
  logic [SLOTS-1:0]          sel_card;
  logic                      map_valid;
  logic [15:0]               step_cnt;

  modport master (
    output reinit, step, sel_step, mode, sel_mode, fill_card,
    input  map, sel_card, map_valid, step_cnt
  );

  modport slave (
    input  reinit, step, sel_step, mode, sel_mode, fill_card,
    output map, sel_card, map_valid, step_cnt
  );
endinterface

// File: rtl/map_pattern_gen_pulse_divider.sv
// Free-running divider: one-cycle tick every AUTO_DIV enabled cycles; held at 0 while disabled.
module pulse_divider #(
  parameter int unsigned AUTO_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);
  localparam int unsigned CW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(AUTO_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/map_pattern_gen.sv
// Card-map stimulus source: slot-by-slot init, then step/auto driven map advances and selection patterns.
module map_pattern_gen
  import map_pattern_gen_pkg::*;
#(
  parameter int unsigned SLOTS       = 144,
  parameter int unsigned CARD_W      = 6,
  parameter int unsigned CARD_MAX    = 54,
  parameter int unsigned SHIFT_CARDS = 2,
  parameter int unsigned AUTO_DIV    = 50000000
) (
  input logic             clk,
  input logic             rst,
  map_pattern_gen_if.slave bus
);
  localparam int unsigned MAP_W = SLOTS * CARD_W;
  localparam int unsigned SH_W  = SHIFT_CARDS * CARD_W;
  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [CARD_W-1:0]  r_card;
  logic [MAP_W-1:0]   r_map, w_map_nxt;
  logic [SLOTS-1:0]   r_sel, w_sel_nxt, w_chk;
  logic [15:0]        r_cnt;
  logic               w_run, w_div_en, w_tick, w_adv;
  map_mode_e          w_mode;
  sel_mode_e          w_sel_mode;

  assign w_mode     = map_mode_e'(bus.mode);
  assign w_sel_mode = sel_mode_e'(bus.sel_mode);
  assign w_run      = (r_state == ST_RUN);
  assign w_div_en   = w_run && !bus.reinit && (w_mode == MODE_AUTO);
  assign w_adv      = w_run && (bus.step || w_tick);

  pulse_divider #(.AUTO_DIV(AUTO_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_div_en),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_idx == IDX_W'(SLOTS - 1)) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
    if (bus.reinit) w_state_nxt = ST_INIT;
  end

  always_comb begin
    w_map_nxt = r_map;
    case (w_mode)
      MODE_SHIFT: begin
        w_map_nxt = r_map >> SH_W;
        for (int unsigned k = SLOTS - SHIFT_CARDS; k < SLOTS; k++) begin
          w_map_nxt[k*CARD_W +: CARD_W] = bus.fill_card;
        end
      end
      MODE_ROTATE, MODE_AUTO: w_map_nxt = {r_map[SH_W-1:0], r_map[MAP_W-1:SH_W]};
      default: w_map_nxt = r_map;
    endcase
  end

  always_comb begin
    w_chk = '0;
    for (int unsigned i = 0; i < SLOTS; i++) w_chk[i] = ~i[0];
    w_sel_nxt = r_sel;
    case (w_sel_mode)
      SEL_TOGGLE: w_sel_nxt = ~r_sel;
      SEL_WALK:   w_sel_nxt = (r_sel == '0) ? SLOTS'(1) : {r_sel[SLOTS-2:0], r_sel[SLOTS-1]};
      SEL_CHECK:  w_sel_nxt = (r_sel == w_chk) ? ~w_chk : w_chk;
      SEL_CLEAR:  w_sel_nxt = '0;
      default:    w_sel_nxt = r_sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
      r_card  <= '0;
      r_map   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.reinit) begin
        r_idx  <= '0;
        r_card <= '0;
        r_map  <= '0;
        r_sel  <= '0;
        r_cnt  <= '0;
      end else if (r_state == ST_INIT) begin
        r_map[r_idx*CARD_W +: CARD_W] <= r_card;
        r_sel[r_idx]                  <= 1'b1;
        r_idx                         <= r_idx + 1'b1;
        r_card <= (r_card == CARD_W'(CARD_MAX)) ? '0 : r_card + 1'b1;
      end else begin
        if (w_adv) begin
          r_map <= w_map_nxt;
          if (w_mode != MODE_STATIC) r_cnt <= r_cnt + 16'd1;
        end
        if (bus.sel_step) r_sel <= w_sel_nxt;
      end
    end
  end

  assign bus.map       = r_map;
  assign bus.sel_card  = r_sel;
  assign bus.map_valid = w_run;
  assign bus.step_cnt  = r_cnt;
endmodule

// File: tb/tb_map_pattern_gen.sv
// Bench for map_pattern_gen: directed scenarios plus random stimulus against a slot-array reference model.
module tb_map_pattern_gen;
  localparam int SLOTS = 8, CARD_W = 6, CARD_MAX = 4, SHIFT_CARDS = 2, AUTO_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  map_pattern_gen_if #(.SLOTS(SLOTS), .CARD_W(CARD_W)) bus ();

  map_pattern_gen #(
    .SLOTS(SLOTS), .CARD_W(CARD_W), .CARD_MAX(CARD_MAX),
    .SHIFT_CARDS(SHIFT_CARDS), .AUTO_DIV(AUTO_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // reference model: slot array, selection mask, advance count, auto phase
  int             m_slot[SLOTS];
  logic [SLOTS-1:0] m_sel;
  int             m_cnt, m_ph, m_pos;
  bit             m_run;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] slots8(int s0, int s1, int s2, int s3, int s4, int s5, int s6, int s7);
    int s[8];
    logic [63:0] v;
    s = '{s0, s1, s2, s3, s4, s5, s6, s7};
    v = '0;
    for (int k = 0; k < 8; k++) v[k*CARD_W +: CARD_W] = s[k][CARD_W-1:0];
    return v;
  endfunction

  function automatic logic [63:0] model_map();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < SLOTS; k++) v[k*CARD_W +: CARD_W] = m_slot[k][CARD_W-1:0];
    return v;
  endfunction

  task automatic model_step();
    int old[SLOTS];
    bit tick;
    if (rst || bus.reinit) begin
      for (int k = 0; k < SLOTS; k++) m_slot[k] = 0;
      m_sel = '0; m_cnt = 0; m_ph = 0; m_pos = 0; m_run = 0;
    end else if (!m_run) begin
      m_slot[m_pos] = m_pos % (CARD_MAX + 1);
      m_sel[m_pos]  = 1'b1;
      m_pos++;
      if (m_pos == SLOTS) m_run = 1;
    end else begin
      tick = (bus.mode == 2'd3) && (m_ph == AUTO_DIV - 1);
      m_ph = (bus.mode == 2'd3) ? (m_ph + 1) % AUTO_DIV : 0;
      if (bus.step || tick) begin
        old = m_slot;
        for (int k = 0; k < SLOTS; k++) begin
          if (bus.mode == 2'd1)
            m_slot[k] = (k + SHIFT_CARDS < SLOTS) ? old[k + SHIFT_CARDS] : int'(bus.fill_card);
          else if (bus.mode != 2'd0)
            m_slot[k] = old[(k + SHIFT_CARDS) % SLOTS];
        end
        if (bus.mode != 2'd0) m_cnt = (m_cnt + 1) % 65536;
      end
      if (bus.sel_step) begin
        case (bus.sel_mode)
          2'd0: m_sel = ~m_sel;
          2'd1: m_sel = (m_sel == 0) ? SLOTS'(1) : {m_sel[SLOTS-2:0], m_sel[SLOTS-1]};
          2'd2: m_sel = (m_sel == 8'h55) ? 8'hAA : 8'h55;
          default: m_sel = '0;
        endcase
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check_eq("m_valid", bus.map_valid, m_run);
      check_eq("m_map",   bus.map,       model_map());
      check_eq("m_sel",   bus.sel_card,  m_sel);
      check_eq("m_cnt",   bus.step_cnt,  m_cnt);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_step();
    bus.step = 1'b1; @(negedge clk); bus.step = 1'b0;
  endtask

  task automatic pulse_sel();
    bus.sel_step = 1'b1; @(negedge clk); bus.sel_step = 1'b0;
  endtask

  task automatic pulse_reinit();
    bus.reinit = 1'b1; @(negedge clk); bus.reinit = 1'b0;
  endtask

  initial begin
    int guard;
    bus.reinit = 0; bus.step = 0; bus.sel_step = 0;
    bus.mode = 0; bus.sel_mode = 0; bus.fill_card = 0;
    cyc(3);
    chk_en = 1;
    check_eq("rst_valid", bus.map_valid, 0);
    check_eq("rst_map",   bus.map, 0);
    check_eq("rst_sel",   bus.sel_card, 0);
    check_eq("rst_cnt",   bus.step_cnt, 0);
    rst = 0;

    // 1: init sequence
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check_eq("init_valid_lo", bus.map_valid, 0);
    end
    cyc(1);
    check_eq("init_valid_hi", bus.map_valid, 1);
    check_eq("init_map", bus.map, slots8(0, 1, 2, 3, 4, 0, 1, 2));
    check_eq("init_sel", bus.sel_card, 8'hFF);
    check_eq("init_cnt", bus.step_cnt, 0);

    // 2: shift-in then static
    bus.mode = 1; bus.fill_card = 6'd52;
    pulse_step();
    check_eq("shift_map", bus.map, slots8(2, 3, 4, 0, 1, 2, 52, 52));
    check_eq("shift_cnt", bus.step_cnt, 1);
    bus.mode = 0;
    pulse_step();
    check_eq("static_map", bus.map, slots8(2, 3, 4, 0, 1, 2, 52, 52));
    check_eq("static_cnt", bus.step_cnt, 1);

    // 3: rotate after fresh init
    pulse_reinit();
    check_eq("reinit_cnt", bus.step_cnt, 0);
    cyc(8);
    bus.mode = 2;
    pulse_step();
    check_eq("rot1_map", bus.map, slots8(2, 3, 4, 0, 1, 2, 0, 1));
    pulse_step();
    check_eq("rot2_map", bus.map, slots8(4, 0, 1, 2, 0, 1, 2, 3));
    check_eq("rot2_cnt", bus.step_cnt, 2);

    // 4: auto rotate, coincident step, freeze
    bus.mode = 3;
    cyc(8);
    check_eq("auto_cnt", bus.step_cnt, 4);
    guard = 0;
    while (m_ph != AUTO_DIV - 1 && guard < 20) begin cyc(1); guard++; end
    check_eq("auto_align", guard < 20, 1);
    pulse_step();
    check_eq("coinc_cnt", bus.step_cnt, 5);
    bus.mode = 0;
    cyc(6);
    check_eq("freeze_cnt", bus.step_cnt, 5);
    bus.mode = 3;
    cyc(3);
    check_eq("restart_cnt_lo", bus.step_cnt, 5);
    cyc(1);
    check_eq("restart_cnt_hi", bus.step_cnt, 6);
    bus.mode = 0;

    // 5: selection patterns
    bus.sel_mode = 3; pulse_sel();
    check_eq("sel_clear", bus.sel_card, 8'h00);
    bus.sel_mode = 1; pulse_sel();
    check_eq("sel_walk0", bus.sel_card, 8'h01);
    repeat (7) pulse_sel();
    check_eq("sel_walk7", bus.sel_card, 8'h80);
    pulse_sel();
    check_eq("sel_wrap", bus.sel_card, 8'h01);
    bus.sel_mode = 2; pulse_sel();
    check_eq("sel_chk", bus.sel_card, 8'h55);
    pulse_sel();
    check_eq("sel_nchk", bus.sel_card, 8'hAA);
    bus.sel_mode = 0; pulse_sel();
    check_eq("sel_tog", bus.sel_card, 8'h55);

    // 6: steps during init ignored, mid-init reinit, rst with reinit
    pulse_reinit();
    bus.mode = 2; bus.step = 1; bus.sel_step = 1;
    cyc(7);
    bus.step = 0; bus.sel_step = 0;
    cyc(1);
    check_eq("ign_valid", bus.map_valid, 1);
    check_eq("ign_map", bus.map, slots8(0, 1, 2, 3, 4, 0, 1, 2));
    check_eq("ign_sel", bus.sel_card, 8'hFF);
    check_eq("ign_cnt", bus.step_cnt, 0);
    pulse_reinit();
    cyc(4);
    pulse_reinit();
    cyc(7);
    check_eq("mid_valid_lo", bus.map_valid, 0);
    cyc(1);
    check_eq("mid_valid_hi", bus.map_valid, 1);
    check_eq("mid_map", bus.map, slots8(0, 1, 2, 3, 4, 0, 1, 2));
    bus.mode = 2; pulse_step();
    rst = 1; bus.reinit = 1; bus.mode = 3;
    cyc(1);
    check_eq("rr_valid", bus.map_valid, 0);
    check_eq("rr_map", bus.map, 0);
    check_eq("rr_sel", bus.sel_card, 0);
    check_eq("rr_cnt", bus.step_cnt, 0);
    rst = 0; bus.reinit = 0;

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.step      = ($urandom % 3) == 0;
      bus.sel_step  = ($urandom % 3) == 0;
      bus.mode      = 2'($urandom % 4);
      bus.sel_mode  = 2'($urandom % 4);
      bus.fill_card = 6'($urandom % 64);
      bus.reinit    = ($urandom % 80) == 0;
      rst           = ($urandom % 250) == 0;
      cyc(1);
    end
    rst = 0; bus.reinit = 0; bus.step = 0; bus.sel_step = 0;
    cyc(2);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
